// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of the single-port data
// memory. Port 0 is the core memory stage, port 1 a loader/DMA master.
// One access is granted per cycle; read data comes back registered with a
// one-cycle rvalid strobe.
// Optional feature: define DMEM_ARB_LOCK_EN to enable bounded locked bursts
// (up to LOCK_MAX consecutive grants to a port holding its lock input).
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  // 1 = port 1 won most recently, so port 0 takes the first tie after reset
  logic          r_last_winner;
  logic          r_m0_rvalid, r_m1_rvalid;
  logic [DW-1:0] r_m0_rdata, r_m1_rdata;

  logic w_rr0, w_rr1;     // pure round-robin decision
  logic w_sel0, w_sel1;   // decision after lock override
  logic w_gnt0, w_gnt1;   // final grants, suppressed during reset
  logic w_rd0, w_rd1;     // granted read on each port

  assign w_rr0 = m0_req & (~m1_req |  r_last_winner);
  assign w_rr1 = m1_req & (~m0_req | ~r_last_winner);

`ifdef DMEM_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {UNLOCKED, LOCKED_P0, LOCKED_P1} lock_state_t;

  lock_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;

  // Lock FSM state and burst counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= UNLOCKED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Lock FSM next state; a locked port overrides round-robin until released
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel0      = w_rr0;
    w_sel1      = w_rr1;
    case (r_state)
      UNLOCKED: begin
        // A lock limit of one is just an ordinary grant, so never enter LOCKED
        if (w_rr0 && m0_lock && LOCK_MAX > 1) begin
          w_state_nxt = LOCKED_P0;
          w_cnt_nxt   = CW'(1);
        end else if (w_rr1 && m1_lock && LOCK_MAX > 1) begin
          w_state_nxt = LOCKED_P1;
          w_cnt_nxt   = CW'(1);
        end
      end
      LOCKED_P0: begin
        if (m0_req && m0_lock) begin
          w_sel0    = 1'b1;
          w_sel1    = 1'b0;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= CW'(LOCK_MAX)) begin
            w_state_nxt = UNLOCKED;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_state_nxt = UNLOCKED;
          w_cnt_nxt   = '0;
        end
      end
      LOCKED_P1: begin
        if (m1_req && m1_lock) begin
          w_sel0    = 1'b0;
          w_sel1    = 1'b1;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= CW'(LOCK_MAX)) begin
            w_state_nxt = UNLOCKED;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_state_nxt = UNLOCKED;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = UNLOCKED;
        w_cnt_nxt   = '0;
      end
    endcase
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = m0_lock ^ m1_lock;
  assign w_sel0        = w_rr0;
  assign w_sel1        = w_rr1;
`endif

  assign w_gnt0 = ~reset & w_sel0;
  assign w_gnt1 = ~reset & w_sel1;
  assign w_rd0  = w_gnt0 & ~m0_we;
  assign w_rd1  = w_gnt1 & ~m1_we;

  // Ungranted cycles present port 0 on the bus; mem_we is qualified by a grant
  assign mem_a  = w_gnt1 ? m1_addr  : m0_addr;
  assign mem_wd = w_gnt1 ? m1_wdata : m0_wdata;
  assign mem_we = (w_gnt0 & m0_we) | (w_gnt1 & m1_we);

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;

  // Round-robin history and registered read return
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_winner <= 1'b1;
      r_m0_rvalid   <= 1'b0;
      r_m1_rvalid   <= 1'b0;
      r_m0_rdata    <= '0;
      r_m1_rdata    <= '0;
    end else begin
      if (w_gnt0 | w_gnt1) r_last_winner <= w_gnt1;
      r_m0_rvalid <= w_rd0;
      r_m1_rvalid <= w_rd1;
      if (w_rd0) r_m0_rdata <= mem_rd;
      if (w_rd1) r_m1_rdata <= mem_rd;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed-vector bench for dmem_arbiter. Inputs change 1ns
// after the rising edge; outputs are checked 1ns after inputs settle.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt, m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m1_req, m1_we, m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt, m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  int n_chk  = 0;
  int n_pass = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
    mem_rd = '0;
  endtask

  // 0 = port 0 wins, 1 = port 1 wins, for six cycles of m0 req+lock vs m1 req
`ifdef DMEM_ARB_LOCK_EN
  logic exp_lock [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
  logic exp_lock [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

  initial begin
    reset = 1;
    idle();
    step();
    step();
    // Requests during reset must not grant or write
    m0_req = 1; m0_we = 1; m0_addr = 32'h0000_0040;
    #1;
    chk("rst_gnt0", m0_gnt, 0);
    chk("rst_we", mem_we, 0);
    step();
    reset = 0;
    idle();
    #1;
    chk("post_rst_gnt0", m0_gnt, 0);
    chk("post_rst_gnt1", m1_gnt, 0);
    chk("post_rst_rv0", m0_rvalid, 0);
    chk("post_rst_rv1", m1_rvalid, 0);
    chk("post_rst_rd0", m0_rdata, 0);
    chk("post_rst_rd1", m1_rdata, 0);
    chk("post_rst_we", mem_we, 0);

    // m0 read alone
    m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0010; mem_rd = 32'hDEAD_BEEF;
    #1;
    chk("rd0_gnt0", m0_gnt, 1);
    chk("rd0_gnt1", m1_gnt, 0);
    chk("rd0_addr", mem_a, 32'h0000_0010);
    chk("rd0_we", mem_we, 0);
    step();
    idle();
    #1;
    chk("rd0_rv0", m0_rvalid, 1);
    chk("rd0_data", m0_rdata, 32'hDEAD_BEEF);
    chk("rd0_rv1", m1_rvalid, 0);
    step();
    chk("rd0_rv0_drop", m0_rvalid, 0);
    chk("rd0_hold", m0_rdata, 32'hDEAD_BEEF);

    // Reset again so the tie history is fresh, then both write
    reset = 1;
    step();
    reset = 0;
    chk("rst2_rd0", m0_rdata, 0);
    m0_req = 1; m0_we = 1; m0_addr = 32'h0000_0100; m0_wdata = 32'h1111_1111;
    m1_req = 1; m1_we = 1; m1_addr = 32'h0000_0200; m1_wdata = 32'h2222_2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("ww_gnt0_%0d", i), m0_gnt, (i % 2) == 0);
      chk($sformatf("ww_gnt1_%0d", i), m1_gnt, (i % 2) == 1);
      chk($sformatf("ww_we_%0d", i), mem_we, 1);
      chk($sformatf("ww_a_%0d", i), mem_a, (i % 2) ? 32'h0000_0200 : 32'h0000_0100);
      chk($sformatf("ww_wd_%0d", i), mem_wd, (i % 2) ? 32'h2222_2222 : 32'h1111_1111);
      step();
      chk($sformatf("ww_rv0_%0d", i), m0_rvalid, 0);
      chk($sformatf("ww_rv1_%0d", i), m1_rvalid, 0);
    end

    // m1 reads the switch register with m0 idle
    idle();
    m1_req = 1; m1_addr = 32'hC000_0000; mem_rd = 32'h0000_02A5;
    #1;
    chk("sw_gnt1", m1_gnt, 1);
    chk("sw_addr", mem_a, 32'hC000_0000);
    step();
    idle();
    #1;
    chk("sw_rv1", m1_rvalid, 1);
    chk("sw_data", m1_rdata, 32'h0000_02A5);
    chk("sw_rv0", m0_rvalid, 0);
    step();
    chk("sw_rv1_drop", m1_rvalid, 0);

    // No grant: bus shows port 0 address and no write
    m0_addr = 32'h0000_0044; m1_addr = 32'h0000_0088; m1_we = 1;
    #1;
    chk("nogrant_a", mem_a, 32'h0000_0044);
    chk("nogrant_we", mem_we, 0);

    // m1 alone back-to-back, one access per cycle
    idle();
    m1_req = 1; m1_addr = 32'h0000_0300;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("b2b_gnt1_%0d", i), m1_gnt, 1);
      step();
      chk($sformatf("b2b_rv1_%0d", i), m1_rvalid, 1);
    end

    // Reset right after an m0 read grant clears the pending rvalid
    idle();
    m0_req = 1; m0_addr = 32'h0000_0020; mem_rd = 32'h0000_1234;
    #1;
    chk("rr_gnt0", m0_gnt, 1);
    step();
    reset = 1; m0_we = 1;
    #1;
    chk("rr_rv0_pre", m0_rvalid, 1);
    chk("rr_gnt_rst", m0_gnt, 0);
    chk("rr_we_rst", mem_we, 0);
    step();
    chk("rr_rv0_clr", m0_rvalid, 0);
    chk("rr_rd0_clr", m0_rdata, 0);
    reset = 0;
    idle();

    // Lock behaviour (round-robin when the lock feature is absent)
    reset = 1;
    step();
    reset = 0;
    m0_req = 1; m0_lock = 1; m0_we = 1; m0_addr = 32'h0000_0500;
    m1_req = 1; m1_we = 1; m1_addr = 32'h0000_0600;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("lk_gnt0_%0d", i), m0_gnt, !exp_lock[i]);
      chk($sformatf("lk_gnt1_%0d", i), m1_gnt, exp_lock[i]);
      step();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
